esdi_cmd_sequencer: RTL and testbench



---
 rtl/esdi_pkg.sv | 30 +++
 rtl/esdi_sync.sv | 33 +++
 rtl/esdi_cmd_sequencer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_esdi_cmd_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esdi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : esdi_pkg
// Purpose  : Shared types and helpers for the ESDI serial command sequencer.
//            Provides the sequencer state encoding, the frame/data widths, and
//            the odd-parity helper used to build outgoing command frames.
// Revision : 1.0  initial release
// ============================================================================
package esdi_pkg;

    localparam int ESDI_FRAME_BITS = 17;
    localparam int ESDI_DATA_BITS  = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_C_SETUP = 3'd1,
        ST_C_REQ   = 3'd2,
        ST_C_REL   = 3'd3,
        ST_R_REQ   = 3'd4,
        ST_R_REL   = 3'd5,
        ST_FIN     = 3'd6
    } esdi_seq_state_t;

    // Parity bit that makes {d, p} contain an odd number of ones.
    function automatic logic esdi_odd_parity(input logic [ESDI_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/esdi_sync.sv
`default_nettype none
// ============================================================================
// Module   : esdi_sync
// Purpose  : Multi-flop synchronizer for one asynchronous drive input.
// Ports    : clk      - destination clock
//            rst_n    - asynchronous active-low clear (all stages to 0)
//            i_async  - asynchronous input
//            o_sync   - synchronized output, SYNC_STAGES cycles of latency
// Revision : 1.0  initial release
// ============================================================================
module esdi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/esdi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : esdi_cmd_sequencer
// Purpose  : Shifts a 16-bit command plus odd parity MSB-first to an ESDI
//            drive, one bit per transfer_req/transfer_ack handshake, and
//            optionally clocks in a 17-bit configuration/status response.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            cmd_valid/cmd_ready   - command accept handshake (SoC side)
//            cmd_word              - command bits, bit 15 sent first
//            cmd_expect_resp       - read a status frame after the command
//            done                  - one-cycle completion/abort pulse
//            resp_word             - received status bits [16:1], held
//            resp_parity_err       - status frame failed odd parity, held
//            timeout_err           - transaction aborted by timeout, held
//            esdi_transfer_req     - handshake request to the drive
//            esdi_command_data     - serial command bit to the drive
//            esdi_transfer_ack     - drive acknowledge (asynchronous)
//            esdi_confstat_data    - serial status bit (asynchronous)
// Revision : 1.0  initial release
// ============================================================================
module esdi_cmd_sequencer
    import esdi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_word,
    input  logic        cmd_expect_resp,
    output logic        done,
    output logic [15:0] resp_word,
    output logic        resp_parity_err,
    output logic        timeout_err,
    output logic        esdi_transfer_req,
    output logic        esdi_command_data,
    input  logic        esdi_transfer_ack,
    input  logic        esdi_confstat_data
);

    localparam int               c_cnt_w      = $clog2(TIMEOUT_CYCLES + 1);
    // The abort fires on the edge where the phase count would reach
    // TIMEOUT_CYCLES, so req drops exactly TIMEOUT_CYCLES cycles after rising.
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [4:0]       c_frame_bits = 5'(ESDI_FRAME_BITS);

    // ------------------------------------------------------------------
    // Synchronized drive inputs
    // ------------------------------------------------------------------
    logic w_ack_s;
    logic w_cs_s;

    esdi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ack (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (esdi_transfer_ack),
        .o_sync  (w_ack_s)
    );

    esdi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (esdi_confstat_data),
        .o_sync  (w_cs_s)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    esdi_seq_state_t r_state;
    esdi_seq_state_t w_state_nxt;

    logic [16:0]        r_shift;
    logic [16:0]        r_resp_sr;
    logic [4:0]         r_bit_cnt;
    logic [c_cnt_w-1:0] r_phase_cnt;
    logic               r_expect_resp;

    logic               r_cmd_ready;
    logic               r_done;
    logic [15:0]        r_resp_word;
    logic               r_parity_err;
    logic               r_timeout_err;
    logic               r_req;
    logic               r_cmd_data;

    logic               w_accept;
    logic               w_phase_active;
    logic               w_expired;
    logic               w_abort;
    logic [16:0]        w_shift_nxt;
    logic               w_ready_nxt;
    logic               w_req_nxt;
    logic               w_done_nxt;
    logic               w_cmd_data_nxt;

    assign w_accept       = cmd_valid && r_cmd_ready;
    assign w_phase_active = (r_state == ST_C_REQ) || (r_state == ST_C_REL) ||
                            (r_state == ST_R_REQ) || (r_state == ST_R_REL);
    assign w_expired      = w_phase_active && (r_phase_cnt == c_cnt_last);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Handshake progress wins over an expiring
    // phase counter on the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_C_SETUP;
                end
            end
            ST_C_SETUP: begin
                w_state_nxt = ST_C_REQ;
            end
            ST_C_REQ: begin
                if (w_ack_s) begin
                    w_state_nxt = ST_C_REL;
                end else if (w_expired) begin
                    w_state_nxt = ST_FIN;
                    w_abort     = 1'b1;
                end
            end
            ST_C_REL: begin
                if (!w_ack_s) begin
                    if (r_bit_cnt == c_frame_bits - 5'd1) begin
                        w_state_nxt = r_expect_resp ? ST_R_REQ : ST_FIN;
                    end else begin
                        w_state_nxt = ST_C_SETUP;
                    end
                end else if (w_expired) begin
                    w_state_nxt = ST_FIN;
                    w_abort     = 1'b1;
                end
            end
            ST_R_REQ: begin
                if (w_ack_s) begin
                    w_state_nxt = ST_R_REL;
                end else if (w_expired) begin
                    w_state_nxt = ST_FIN;
                    w_abort     = 1'b1;
                end
            end
            ST_R_REL: begin
                if (!w_ack_s) begin
                    w_state_nxt = (r_bit_cnt == c_frame_bits) ? ST_FIN : ST_R_REQ;
                end else if (w_expired) begin
                    w_state_nxt = ST_FIN;
                    w_abort     = 1'b1;
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic. Outputs are registered, so each is computed from
    // the state being entered.
    // ------------------------------------------------------------------
    always_comb begin
        w_shift_nxt = r_shift;
        if (w_accept) begin
            w_shift_nxt = {cmd_word, esdi_odd_parity(cmd_word)};
        end else if ((r_state == ST_C_REL) && !w_ack_s) begin
            w_shift_nxt = {r_shift[15:0], 1'b0};
        end

        w_ready_nxt = (w_state_nxt == ST_IDLE) && !w_ack_s;
        w_req_nxt   = (w_state_nxt == ST_C_REQ) || (w_state_nxt == ST_R_REQ);
        w_done_nxt  = (w_state_nxt == ST_FIN);

        // Data is presented in C_SETUP and held until the bit's ack falls.
        case (w_state_nxt)
            ST_C_SETUP: w_cmd_data_nxt = w_shift_nxt[16];
            ST_C_REQ,
            ST_C_REL:   w_cmd_data_nxt = r_cmd_data;
            default:    w_cmd_data_nxt = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift       <= '0;
            r_resp_sr     <= '0;
            r_bit_cnt     <= '0;
            r_phase_cnt   <= '0;
            r_expect_resp <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_done        <= 1'b0;
            r_resp_word   <= '0;
            r_parity_err  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_req         <= 1'b0;
            r_cmd_data    <= 1'b0;
        end else begin
            r_shift     <= w_shift_nxt;
            r_cmd_ready <= w_ready_nxt;
            r_req       <= w_req_nxt;
            r_done      <= w_done_nxt;
            r_cmd_data  <= w_cmd_data_nxt;

            if ((w_state_nxt != r_state) || !w_phase_active) begin
                r_phase_cnt <= '0;
            end else begin
                r_phase_cnt <= r_phase_cnt + c_cnt_one;
            end

            if (w_accept) begin
                r_expect_resp <= cmd_expect_resp;
                r_bit_cnt     <= '0;
                r_resp_sr     <= '0;
                r_resp_word   <= '0;
                r_parity_err  <= 1'b0;
                r_timeout_err <= 1'b0;
            end else begin
                case (r_state)
                    ST_C_REL: begin
                        // The counter restarts at 0 for the response frame.
                        if (!w_ack_s) begin
                            r_bit_cnt <= (r_bit_cnt == c_frame_bits - 5'd1) ?
                                         5'd0 : r_bit_cnt + 5'd1;
                        end
                    end
                    ST_R_REQ: begin
                        if (w_ack_s) begin
                            r_resp_sr <= {r_resp_sr[15:0], w_cs_s};
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                        end
                    end
                    ST_R_REL: begin
                        if (!w_ack_s && (r_bit_cnt == c_frame_bits)) begin
                            r_resp_word  <= r_resp_sr[16:1];
                            r_parity_err <= ~^r_resp_sr;
                        end
                    end
                    default: begin
                    end
                endcase
                if (w_abort) begin
                    r_timeout_err <= 1'b1;
                end
            end
        end
    end

    assign cmd_ready         = r_cmd_ready;
    assign done              = r_done;
    assign resp_word         = r_resp_word;
    assign resp_parity_err   = r_parity_err;
    assign timeout_err       = r_timeout_err;
    assign esdi_transfer_req = r_req;
    assign esdi_command_data = r_cmd_data;

endmodule
`default_nettype wire

// File: tb/tb_esdi_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_esdi_cmd_sequencer
// Purpose  : Self-checking bench for esdi_cmd_sequencer: a drive-side model
//            answers each handshake; a vector table (fixed and $urandom
//            entries) is compared against frame/status rules, followed by
//            timeout, stuck-ack and reset-mid-command sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_esdi_cmd_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_word;
    logic        cmd_expect_resp;
    logic        done;
    logic [15:0] resp_word;
    logic        resp_parity_err;
    logic        timeout_err;
    logic        esdi_transfer_req;
    logic        esdi_command_data;
    logic        esdi_transfer_ack;
    logic        esdi_confstat_data;

    esdi_cmd_sequencer #(.TIMEOUT_CYCLES(100), .SYNC_STAGES(2)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_word           (cmd_word),
        .cmd_expect_resp    (cmd_expect_resp),
        .done               (done),
        .resp_word          (resp_word),
        .resp_parity_err    (resp_parity_err),
        .timeout_err        (timeout_err),
        .esdi_transfer_req  (esdi_transfer_req),
        .esdi_command_data  (esdi_command_data),
        .esdi_transfer_ack  (esdi_transfer_ack),
        .esdi_confstat_data (esdi_confstat_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- drive-side model ----------------
    int          hs_count     = 0;
    logic [16:0] rx_frame     = '0;
    logic [16:0] bfm_status   = '0;
    int          bfm_delay    = 3;
    int          bfm_noack_at = -1;
    int          bfm_stuck_at = -1;
    bit          bfm_release  = 1'b0;
    int          req_rise_cyc = 0;
    int          req_fall_cyc = 0;

    initial begin
        int idx;
        esdi_transfer_ack  = 1'b0;
        esdi_confstat_data = 1'b0;
        forever begin
            @(negedge clk);
            if (esdi_transfer_req === 1'b1) begin
                idx      = hs_count;
                hs_count = hs_count + 1;
                if (idx < 17) rx_frame[16-idx] = esdi_command_data;
                else if (idx < 34) esdi_confstat_data = bfm_status[33-idx];
                req_rise_cyc = cyc;
                if (idx == bfm_noack_at) begin
                    while (esdi_transfer_req === 1'b1) @(negedge clk);
                    req_fall_cyc = cyc;
                end else begin
                    repeat (bfm_delay) @(negedge clk);
                    esdi_transfer_ack = 1'b1;
                    while (esdi_transfer_req === 1'b1) @(negedge clk);
                    if (idx == bfm_stuck_at) while (!bfm_release) @(negedge clk);
                    esdi_transfer_ack = 1'b0;
                end
            end
        end
    end

    int done_cnt = 0;
    int done_cyc = 0;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] word;
        logic        er;
        logic [16:0] status;
        int          delay;
        logic [16:0] exp_frame;
        int          exp_hs;
        logic [15:0] exp_resp;
        logic        exp_perr;
    } vec_t;

    function automatic logic [16:0] good_frame(input logic [15:0] w);
        return {w, ($countones(w) % 2 == 0)};
    endfunction

    function automatic vec_t make_vec(input logic [15:0] w, input logic er,
                                      input logic [16:0] st, input int d);
        vec_t v;
        v.word      = w;
        v.er        = er;
        v.status    = st;
        v.delay     = d;
        v.exp_frame = good_frame(w);
        v.exp_hs    = er ? 34 : 17;
        v.exp_resp  = er ? st[16:1] : 16'h0000;
        v.exp_perr  = er && ($countones(st) % 2 == 0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [15:0] w, input logic er);
        int t;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_word        = w;
        cmd_expect_resp = er;
        cmd_valid       = 1'b1;
        @(negedge clk);
        cmd_valid       = 1'b0;
    endtask

    task automatic wait_done(input int start_cnt, input int budget, output bit ok);
        int t;
        t = 0;
        while (done_cnt == start_cnt && t < budget) begin
            @(negedge clk);
            t++;
        end
        ok = (done_cnt != start_cnt);
    endtask

    vec_t vecs[10];

    initial begin
        bit          ok;
        int          d0;
        bit          ready_seen;
        bit          req_seen;
        int          t;

        rst_n           = 1'b0;
        cmd_valid       = 1'b0;
        cmd_word        = '0;
        cmd_expect_resp = 1'b0;

        vecs[0] = make_vec(16'h0001, 1'b0, 17'h0, 3);
        vecs[1] = make_vec(16'hA5A5, 1'b1, good_frame(16'h1234), 3);
        vecs[2] = make_vec(16'hA5A5, 1'b1, good_frame(16'h1234) ^ 17'h1, 3);
        vecs[3] = make_vec(16'hFFFF, 1'b1, 17'h1FFFF, 0);
        vecs[4] = make_vec(16'h0000, 1'b0, 17'h0, 0);
        for (int i = 5; i < 10; i++) begin
            vecs[i] = make_vec(16'($urandom), 1'($urandom_range(0, 1)),
                               17'($urandom), int'($urandom_range(0, 4)));
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(esdi_transfer_req), 32'd0);
        chk("rst_cmd_data", 32'(esdi_command_data), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_resp_word", 32'(resp_word), 32'd0);
        chk("rst_perr", 32'(resp_parity_err), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Table-driven commands
        for (int i = 0; i < 10; i++) begin
            hs_count   = 0;
            rx_frame   = '0;
            bfm_delay  = vecs[i].delay;
            bfm_status = vecs[i].status;
            d0         = done_cnt;
            send_cmd(vecs[i].word, vecs[i].er);
            wait_done(d0, 3000, ok);
            chk("done_seen", 32'(ok), 32'd1);
            repeat (4) @(negedge clk);
            chk("handshakes", 32'(hs_count), 32'(vecs[i].exp_hs));
            chk("cmd_frame", 32'(rx_frame), 32'(vecs[i].exp_frame));
            chk("done_pulses", 32'(done_cnt - d0), 32'd1);
            chk("resp_word", 32'(resp_word), 32'(vecs[i].exp_resp));
            chk("resp_perr", 32'(resp_parity_err), 32'(vecs[i].exp_perr));
            chk("timeout_err", 32'(timeout_err), 32'd0);
            chk("ready_after", 32'(cmd_ready), 32'd1);
        end

        // Timeout: drive never acks bit 5
        hs_count     = 0;
        bfm_delay    = 2;
        bfm_noack_at = 5;
        d0           = done_cnt;
        send_cmd(16'h5A5A, 1'b1);
        wait_done(d0, 1000, ok);
        chk("tmo_done_seen", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        chk("tmo_req_width", 32'(req_fall_cyc - req_rise_cyc), 32'd100);
        chk("tmo_done_at_drop", 32'(done_cyc), 32'(req_fall_cyc));
        chk("tmo_err", 32'(timeout_err), 32'd1);
        chk("tmo_resp_word", 32'(resp_word), 32'd0);
        chk("tmo_perr", 32'(resp_parity_err), 32'd0);
        chk("tmo_handshakes", 32'(hs_count), 32'd6);
        chk("tmo_ready", 32'(cmd_ready), 32'd1);
        bfm_noack_at = -1;

        // Stuck ack: drive holds ack high on bit 3
        hs_count     = 0;
        bfm_stuck_at = 3;
        bfm_release  = 1'b0;
        d0           = done_cnt;
        send_cmd(16'h1357, 1'b0);
        wait_done(d0, 1000, ok);
        chk("stuck_done_seen", 32'(ok), 32'd1);
        chk("stuck_tmo_err", 32'(timeout_err), 32'd1);
        cmd_word   = 16'hFFFF;
        cmd_valid  = 1'b1;
        ready_seen = 1'b0;
        req_seen   = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) ready_seen = 1'b1;
            if (esdi_transfer_req === 1'b1) req_seen = 1'b1;
        end
        cmd_valid = 1'b0;
        chk("stuck_ready_low", 32'(ready_seen), 32'd0);
        chk("stuck_no_req", 32'(req_seen), 32'd0);
        chk("stuck_handshakes", 32'(hs_count), 32'd4);
        bfm_release = 1'b1;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("stuck_ready_after_release", 32'(cmd_ready), 32'd1);
        bfm_release  = 1'b0;
        bfm_stuck_at = -1;

        // Reset during bit 8
        hs_count  = 0;
        bfm_delay = 3;
        send_cmd(16'hC3C3, 1'b1);
        t = 0;
        while (hs_count <= 8 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("rstmid_reached_bit8", 32'(hs_count > 8), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_req", 32'(esdi_transfer_req), 32'd0);
        chk("rstmid_ready", 32'(cmd_ready), 32'd1);
        chk("rstmid_cmd_data", 32'(esdi_command_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        hs_count = 0;
        rx_frame = '0;
        d0       = done_cnt;
        send_cmd(16'h8001, 1'b0);
        wait_done(d0, 3000, ok);
        chk("rstmid_done_seen", 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        chk("rstmid_handshakes", 32'(hs_count), 32'd17);
        chk("rstmid_frame", 32'(rx_frame), 32'(good_frame(16'h8001)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
